// File: rtl/fmul_norm_ctrl_if.sv
// Handshake bundle between the FloatMul rounding stage, the normalization
// controller and the result packer. The master drives operands and out_ready.
interface fmul_norm_ctrl_if #(
    parameter int MW = 11,
    parameter int EW = 5,
    parameter int SW = 4
);
    logic          in_valid;
    logic          in_ready;
    logic [MW-1:0] in_mant;
    logic [EW-1:0] in_exp;
    logic          out_valid;
    logic          out_ready;
    logic [MW-1:0] out_mant;
    logic [EW-1:0] out_exp;
    logic [SW-1:0] out_shamt;
    logic          out_zero;
    logic          out_uflow;

    modport master (
        output in_valid, in_mant, in_exp, out_ready,
        input  in_ready, out_valid, out_mant, out_exp, out_shamt, out_zero, out_uflow
    );

    modport slave (
        input  in_valid, in_mant, in_exp, out_ready,
        output in_ready, out_valid, out_mant, out_exp, out_shamt, out_zero, out_uflow
    );
endinterface

// File: rtl/fmul_norm_ctrl.sv
// Iterative left-normalization controller: shifts the significand until bit MW-1 is set.
// Optional NORM_FAST4_EN adds a 4-bit shift step when the top nibble is zero.
module fmul_norm_ctrl #(
    parameter int MW = 11,
    parameter int EW = 5,
    parameter int SW = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fmul_norm_ctrl_if.slave       bus,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t        state;
    logic [MW-1:0] mant_p0;
    logic [EW-1:0] exp_p0;
    logic [SW-1:0] shamt_p0;
    logic          zero_p0;
    logic          uflow_p0;
    logic          vld_p0;

    logic          shift_sel;
    logic          step4;
    logic [MW-1:0] step_mant;
    logic [EW-1:0] step_exp;
    logic [SW-1:0] step_shamt;
    logic          step_stop;
    logic          step_uflow;

    // Exponent decrement that clamps at zero instead of wrapping.
    function automatic logic [EW-1:0] sat_dec(input logic [EW-1:0] e, input logic [EW-1:0] d);
        return (e >= d) ? (e - d) : '0;
    endfunction

    always_comb begin
        shift_sel = (state == SHIFT);
        step4     = 1'b0;
`ifdef NORM_FAST4_EN
        step4     = shift_sel && (mant_p0[MW-1:MW-4] == 4'd0) && (exp_p0 >= EW'(4));
`endif
        step_mant  = mant_p0;
        step_exp   = exp_p0;
        step_shamt = shamt_p0;
        if (step4) begin
            step_mant  = mant_p0 << 4;
            step_exp   = sat_dec(exp_p0, EW'(4));
            step_shamt = shamt_p0 + SW'(4);
        end else if (shift_sel) begin
            step_mant  = mant_p0 << 1;
            step_exp   = sat_dec(exp_p0, EW'(1));
            step_shamt = shamt_p0 + SW'(1);
        end
        step_stop  = step_mant[MW-1] || (step_exp == '0);
        step_uflow = (step_exp == '0) && !step_mant[MW-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            mant_p0  <= '0;
            exp_p0   <= '0;
            shamt_p0 <= '0;
            zero_p0  <= 1'b0;
            uflow_p0 <= 1'b0;
            vld_p0   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        mant_p0  <= bus.in_mant;
                        exp_p0   <= bus.in_exp;
                        shamt_p0 <= '0;
                        zero_p0  <= 1'b0;
                        uflow_p0 <= 1'b0;
                        if (bus.in_mant == '0) begin
                            exp_p0  <= '0;
                            zero_p0 <= 1'b1;
                            state   <= DONE;
                            vld_p0  <= 1'b1;
                        end else if (bus.in_mant[MW-1]) begin
                            state  <= DONE;
                            vld_p0 <= 1'b1;
                        end else if (bus.in_exp == '0) begin
                            uflow_p0 <= 1'b1;
                            state    <= DONE;
                            vld_p0   <= 1'b1;
                        end else begin
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    mant_p0  <= step_mant;
                    exp_p0   <= step_exp;
                    shamt_p0 <= step_shamt;
                    if (step_stop) begin
                        uflow_p0 <= step_uflow;
                        state    <= DONE;
                        vld_p0   <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state  <= IDLE;
                        vld_p0 <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    vld_p0 <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign busy          = (state != IDLE);
    assign bus.out_valid = vld_p0;
    assign bus.out_mant  = mant_p0;
    assign bus.out_exp   = exp_p0;
    assign bus.out_shamt = shamt_p0;
    assign bus.out_zero  = zero_p0;
    assign bus.out_uflow = uflow_p0;

endmodule

// File: tb/tb_fmul_norm_ctrl.sv
// Scoreboard bench for fmul_norm_ctrl: directed operands push expected results,
// an independent monitor pops and checks them when out_valid appears.
module tb_fmul_norm_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    int   cyc = 0;
    int   compared = 0;
    int   mismatched = 0;
    bit   holding = 0;

    typedef struct {
        logic [10:0] m;
        logic [4:0]  e;
        logic [3:0]  s;
        logic        z;
        logic        u;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    exp_t cap;

    fmul_norm_ctrl_if #(.MW(11), .EW(5), .SW(4)) bus();

    fmul_norm_ctrl #(.MW(11), .EW(5), .SW(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input int act, input int req);
        compared++;
        if (act != req) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: first cycle of a result is checked against the scoreboard,
    // later held cycles must repeat the same values.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid) begin
            if (!holding) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    cap = sb.pop_front();
                    check("out_mant", int'(bus.out_mant), int'(cap.m));
                    check("out_exp", int'(bus.out_exp), int'(cap.e));
                    check("out_shamt", int'(bus.out_shamt), int'(cap.s));
                    check("out_zero", int'(bus.out_zero), int'(cap.z));
                    check("out_uflow", int'(bus.out_uflow), int'(cap.u));
                    check("latency", cyc - cap.acc + 1, cap.lat);
                end
                holding = 1;
            end else begin
                check("hold_mant", int'(bus.out_mant), int'(cap.m));
                check("hold_exp", int'(bus.out_exp), int'(cap.e));
                check("hold_shamt", int'(bus.out_shamt), int'(cap.s));
                check("hold_in_ready", int'(bus.in_ready), 0);
            end
            if (bus.out_ready) holding = 0;
        end
    end

    task automatic send(input logic [10:0] im, input logic [4:0] ie,
                        input logic [10:0] em, input logic [4:0] ee, input logic [3:0] es,
                        input bit ez, input bit eu, input int lat_s, input int lat_f,
                        input bit push);
        exp_t x;
        bit   ok;
        ok = 0;
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.in_mant  = im;
        bus.in_exp   = ie;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            check("accept_timeout", 0, 1);
        end else if (push) begin
            x.m = em; x.e = ee; x.s = es; x.z = ez; x.u = eu;
`ifdef NORM_FAST4_EN
            x.lat = lat_f;
`else
            x.lat = lat_s;
`endif
            x.acc = cyc + 1;
            sb.push_back(x);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_mant   = '0;
        bus.in_exp    = '0;
        bus.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_out_mant", int'(bus.out_mant), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", int'(bus.in_ready), 1);

        send(11'h0C0, 5'd15, 11'h600, 5'd12, 4'd3, 0, 0, 4, 4, 1);
        send(11'h001, 5'd30, 11'h400, 5'd20, 4'd10, 0, 0, 11, 5, 1);
        send(11'h010, 5'd3, 11'h080, 5'd0, 4'd3, 0, 1, 4, 4, 1);
        send(11'h000, 5'd9, 11'h000, 5'd0, 4'd0, 1, 0, 1, 1, 1);
        send(11'h7FF, 5'd9, 11'h7FF, 5'd9, 4'd0, 0, 0, 1, 1, 1);
        send(11'h100, 5'd0, 11'h100, 5'd0, 4'd0, 0, 1, 1, 1, 1);
        send(11'h020, 5'd8, 11'h400, 5'd3, 4'd5, 0, 0, 6, 3, 1);
        send(11'h001, 5'd4, 11'h010, 5'd0, 4'd4, 0, 1, 5, 2, 1);

        // Backpressure: first result held 5 extra cycles while the next operand waits.
        for (int i = 0; i < 20; i++) begin
            if (sb.size() == 0 && !bus.out_valid) break;
            @(negedge clk);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        send(11'h0C0, 5'd15, 11'h600, 5'd12, 4'd3, 0, 0, 4, 4, 1);
        fork
            send(11'h7FF, 5'd9, 11'h7FF, 5'd9, 4'd0, 0, 0, 1, 1, 1);
            begin
                for (int i = 0; i < 40; i++) begin
                    @(negedge clk);
                    if (bus.out_valid) break;
                end
                repeat (5) @(negedge clk);
                @(posedge clk); #1;
                bus.out_ready = 1'b1;
            end
        join

        // Reset while shifting discards the operand.
        for (int i = 0; i < 20; i++) begin
            if (sb.size() == 0 && !bus.out_valid) break;
            @(negedge clk);
        end
        send(11'h001, 5'd20, 11'h000, 5'd0, 4'd0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("midshift_busy_before", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_out_valid", int'(bus.out_valid), 0);
        check("midrst_out_mant", int'(bus.out_mant), 0);
        check("midrst_out_exp", int'(bus.out_exp), 0);
        check("midrst_out_shamt", int'(bus.out_shamt), 0);
        check("midrst_flags", int'({bus.out_zero, bus.out_uflow}), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", int'(bus.in_ready), 1);

        send(11'h0C0, 5'd15, 11'h600, 5'd12, 4'd3, 0, 0, 4, 4, 1);
        for (int i = 0; i < 100; i++) begin
            if (sb.size() == 0 && !holding) break;
            @(negedge clk);
        end
        check("scoreboard_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
